iir_tap_acc: RTL and testbench
==============================

IIR_TAP_ACC -- requirements
Module: iir_tap_acc

Interface
REQ-001 SHALL have parameter NTAPS, default 5, meaning the number of product beats summed per output sample (b0,b1,b2,a1,a2).
REQ-002 SHALL have parameter ACC_W, default 8, meaning the signed accumulator width (guard bits over DATA_W).
REQ-003 SHALL have parameter DATA_W, default 4, meaning the signed Q2.2 product/output width, matching i4_mul P.
REQ-004 SHALL have port clk  in  1  clock; one clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  product beat valid.
REQ-007 SHALL have port in_ready  out  1  block accepts a beat.
REQ-008 SHALL have port in_p  in  DATA_W  signed product from i4_mul P.
REQ-009 SHALL have port in_ov  in  1  i4_mul OV for this beat.
REQ-010 SHALL have port in_sub  in  1  1 = subtract beat (feedback tap), 0 = add.
REQ-011 SHALL have port out_valid  out  1  output sample valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts the sample.
REQ-013 SHALL have port out_y  out  DATA_W  signed saturated sum.
REQ-014 SHALL have port out_ov  out  1  sticky OR of in_ov over the frame.
REQ-015 SHALL have port out_sat  out  1  out_y was clipped.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, DONE; IDLE→ACC on first accepted beat; ACC→DONE on accepted beat NTAPS; DONE→IDLE on out_valid&&out_ready.
REQ-017 SHALL drive in_ready=1 in IDLE and ACC, 0 in DONE; a beat is accepted only on in_valid&&in_ready.
REQ-018 SHALL, on a beat accepted in IDLE, load acc = ±sext(in_p); in ACC, update acc = acc ± sext(in_p); sign extension SHALL precede negation (−(−8) = +8).
REQ-019 SHALL count accepted beats 1..NTAPS; no wrap; count clears on entering IDLE.
REQ-020 SHALL accumulate out_ov as the OR of in_ov over the frame's beats; it is loaded (not ORed) on the first beat.
REQ-021 SHALL saturate on DONE entry: acc>+7 → 0111, acc<−8 → 1000, else low DATA_W bits; out_sat=1 iff clipped.
REQ-022 SHALL assert out_valid in the cycle after the NTAPS-th accepted beat (latency 1); out_y/out_ov/out_sat registered.
REQ-023 SHALL hold out_y, out_ov, out_sat and out_valid stable while out_valid&&!out_ready.
REQ-024 SHALL accept out_ready high in the same cycle out_valid rises; the next frame's first beat is accepted no earlier than the following cycle (frame period ≥ NTAPS+1).
REQ-025 SHALL ignore in_valid, in_p, in_sub and in_ov when in_ready=0.
REQ-026 SHALL NOT wrap acc for NTAPS·2^(DATA_W−1) ≤ 2^(ACC_W−1)−1; parameter combinations violating this are illegal.

Reset
REQ-027 SHALL, on rst, asynchronously force state=IDLE, acc=0, count=0, out_valid=0, out_y=0, out_ov=0, out_sat=0; in_ready=1 once rst deasserts.
REQ-028 SHALL discard a partially accumulated frame on reset mid-operation; no output is produced for it.

Structure
REQ-029 SHALL take DATA_W, ACC_W and NTAPS defaults and the FSM state encoding from shared package iir_pkg.
REQ-030 SHALL place the clip logic in sub-module iir_sat (ACC_W in → DATA_W out + sat flag), reusable by other filter stages.

Verification
REQ-031 SHALL test: 5 beats p=0001 add → out_y=0101, out_sat=0, out_ov=0, out_valid 1 cycle after beat 5.
REQ-032 SHALL test: 5 beats p=0111 add (sum 35) → out_y=0111, out_sat=1; 5 beats p=1000 add → out_y=1000, out_sat=1.
REQ-033 SHALL test: beats (−8 sub),(−8 add),(+3 add),(−2 sub),(−4 add) → sum 1 → out_y=0001, out_sat=0.
REQ-034 SHALL test: in_ov=1 on beat 3 only → out_ov=1; next clean frame → out_ov=0.
REQ-035 SHALL test: out_ready low 4 cycles after out_valid with in_valid held high → out_y stable, in_ready=0, no beat taken; on out_ready=1 → IDLE, next frame correct.
REQ-036 SHALL test: rst pulse after 2 beats → out_valid=0, in_ready=1, acc=0; following 5-beat frame of 0001 → out_y=0101.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared widths and FSM encoding for the IIR tap accumulator and related filter stages.
package iir_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int ACC_W_DEF  = 8;
  localparam int NTAPS_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/iir_sat.sv
// Clips a signed ACC_W accumulator into the signed DATA_W output range and flags clipping.
module iir_sat #(
  parameter int ACC_W  = 8,
  parameter int DATA_W = 4
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic        [DATA_W-1:0] o_y,
  output logic                     o_sat
);
  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LIM_LO = -LIM_HI - ACC_W'(1);

  logic w_hi;
  logic w_lo;

  assign w_hi = (i_acc > LIM_HI);
  assign w_lo = (i_acc < LIM_LO);

  always_comb begin
    o_y   = i_acc[DATA_W-1:0];
    o_sat = 1'b0;
    if (w_hi) begin
      o_y   = LIM_HI[DATA_W-1:0];
      o_sat = 1'b1;
    end else if (w_lo) begin
      o_y   = LIM_LO[DATA_W-1:0];
      o_sat = 1'b1;
    end
  end
endmodule

// File: rtl/iir_tap_acc.sv
// Sums NTAPS signed product beats (add or subtract) into one saturated output sample per frame.
// Handshake: a transfer happens on a rising edge where valid && ready; valid, once high, holds its payload until ready.
module iir_tap_acc
  import iir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_p,
  input  logic              in_ov,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_ov,
  output logic              out_sat,
  output logic [1:0]        dbg_state,
  output logic [ACC_W-1:0]  dbg_acc
);
  localparam int                CNT_W = $clog2(NTAPS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NTAPS - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_ov;
  logic [DATA_W-1:0]        r_out_y;
  logic                     r_out_sat;

  logic                     w_accept;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_p_ext;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0]        w_sat_y;
  logic                     w_sat;

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_count == LAST);

  // Widen before negating so the most negative product flips to a positive value.
  assign w_p_ext   = ACC_W'($signed(in_p));
  assign w_term    = in_sub ? -w_p_ext : w_p_ext;
  assign w_acc_nxt = (r_state == IDLE) ? w_term : (r_acc + w_term);

  iir_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat (
    .i_acc (w_acc_nxt),
    .o_y   (w_sat_y),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_last ? DONE : ACC;
      ACC:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_ov      <= 1'b0;
      r_out_y   <= '0;
      r_out_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CNT_W'(1);
      r_ov    <= (r_state == IDLE) ? in_ov : (r_ov | in_ov);
      if (w_last) begin
        r_out_y   <= w_sat_y;
        r_out_sat <= w_sat;
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_count <= '0;
    end
  end

  assign out_y     = r_out_y;
  assign out_ov    = r_ov;
  assign out_sat   = r_out_sat;
  assign dbg_state = r_state;
  assign dbg_acc   = r_acc;
endmodule

// File: tb/tb_iir_tap_acc.sv
// Bench for iir_tap_acc: directed frames plus randomized frames scored against an integer model.
module tb_iir_tap_acc;
  localparam int DATA_W = 4;
  localparam int ACC_W  = 8;
  localparam int NTAPS  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_p = '0;
  logic              in_ov = 1'b0;
  logic              in_sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_y;
  logic              out_ov;
  logic              out_sat;
  logic [1:0]        dbg_state;
  logic [ACC_W-1:0]  dbg_acc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] f_p   [NTAPS];
  logic              f_sub [NTAPS];
  logic              f_ov  [NTAPS];

  logic [DATA_W+1:0] exp_q[$];

  iir_tap_acc #(.NTAPS(NTAPS), .ACC_W(ACC_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_ov     (in_ov),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_ov    (out_ov),
    .out_sat   (out_sat),
    .dbg_state (dbg_state),
    .dbg_acc   (dbg_acc)
  );

  always #5 clk = ~clk;

  // Reference: plain integer sum of signed beats, clipped to the Q2.2 range.
  function automatic logic [DATA_W+1:0] model_frame();
    int s = 0;
    int v;
    logic ov = 1'b0;
    logic sat = 1'b0;
    logic [DATA_W-1:0] y;
    for (int i = 0; i < NTAPS; i++) begin
      v = int'($signed(f_p[i]));
      s = f_sub[i] ? s - v : s + v;
      ov = ov | f_ov[i];
    end
    if (s > 7) begin
      s = 7; sat = 1'b1;
    end else if (s < -8) begin
      s = -8; sat = 1'b1;
    end
    y = DATA_W'(s);
    return {ov, sat, y};
  endfunction

  task automatic set_frame(input logic [DATA_W-1:0] p, input logic sub);
    for (int i = 0; i < NTAPS; i++) begin
      f_p[i] = p; f_sub[i] = sub; f_ov[i] = 1'b0;
    end
  endtask

  task automatic send_frame(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_p     = DATA_W'($urandom);
        in_sub   = 1'($urandom);
        in_ov    = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_p     = f_p[i];
      in_sub   = f_sub[i];
      in_ov    = f_ov[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [DATA_W+1:0] exp_v);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
    end
    n_tests++;
    if ({out_ov, out_sat, out_y} !== exp_v) begin
      n_fail++;
      $display("FAIL %s {ov,sat,y}: got %b expected %b", name, {out_ov, out_sat, out_y}, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_tests++;
    if ({out_valid, out_y, out_ov, out_sat, dbg_acc, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b y=%b ov=%b sat=%b acc=%h st=%0d expected all zero",
               out_valid, out_y, out_ov, out_sat, dbg_acc, dbg_state);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    set_frame(4'b0001, 1'b0);
    send_frame(0, NTAPS - 2, 0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    send_frame(NTAPS - 1, NTAPS - 1, 0);
    check_frame("basic", {1'b0, 1'b0, 4'b0101});
    release_output();
  endtask

  task automatic test_saturate();
    set_frame(4'b0111, 1'b0);
    send_frame(0, NTAPS - 1, 0);
    check_frame("sat_hi", {1'b0, 1'b1, 4'b0111});
    release_output();
    set_frame(4'b1000, 1'b0);
    send_frame(0, NTAPS - 1, 0);
    check_frame("sat_lo", {1'b0, 1'b1, 4'b1000});
    release_output();
  endtask

  task automatic load_mixed();
    f_p[0] = 4'b1000; f_sub[0] = 1'b1; f_ov[0] = 1'b0;
    f_p[1] = 4'b1000; f_sub[1] = 1'b0; f_ov[1] = 1'b0;
    f_p[2] = 4'b0011; f_sub[2] = 1'b0; f_ov[2] = 1'b0;
    f_p[3] = 4'b1110; f_sub[3] = 1'b1; f_ov[3] = 1'b0;
    f_p[4] = 4'b1100; f_sub[4] = 1'b0; f_ov[4] = 1'b0;
  endtask

  task automatic test_mixed_sub();
    load_mixed();
    send_frame(0, NTAPS - 1, 0);
    n_tests++;
    if (dbg_acc !== 8'h01) begin
      n_fail++;
      $display("FAIL mixed_acc: got %h expected 01", dbg_acc);
    end
    check_frame("mixed", {1'b0, 1'b0, 4'b0001});
    release_output();
  endtask

  task automatic test_overflow_flag();
    set_frame(4'b0001, 1'b0);
    f_ov[2] = 1'b1;
    send_frame(0, NTAPS - 1, 0);
    check_frame("ov_set", {1'b1, 1'b0, 4'b0101});
    release_output();
    set_frame(4'b0010, 1'b1);
    send_frame(0, NTAPS - 1, 0);
    check_frame("ov_clear", {1'b0, 1'b1, 4'b1000});
    release_output();
  endtask

  task automatic test_backpressure();
    set_frame(4'b0001, 1'b0);
    send_frame(0, NTAPS - 1, 0);
    check_frame("bp_first", {1'b0, 1'b0, 4'b0101});
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_p = DATA_W'($urandom); in_sub = 1'($urandom); in_ov = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, out_ov, out_sat, out_y, dbg_acc} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 8'h05}) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got valid=%b rdy=%b ov=%b sat=%b y=%b acc=%h expected 1 0 0 0 0101 05",
                 c, out_valid, in_ready, out_ov, out_sat, out_y, dbg_acc);
      end
    end
    in_valid = 1'b0;
    release_output();
    n_tests++;
    if ({out_valid, in_ready, dbg_state} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b rdy=%b st=%0d expected 0 1 0", out_valid, in_ready, dbg_state);
    end
    load_mixed();
    send_frame(0, NTAPS - 1, 0);
    check_frame("bp_next", {1'b0, 1'b0, 4'b0001});
    release_output();
  endtask

  task automatic test_reset_mid();
    set_frame(4'b0011, 1'b0);
    send_frame(0, 1, 0);
    rst = 1'b1;
    #2;
    n_tests++;
    if ({out_valid, in_ready, dbg_acc, dbg_state} !== {1'b0, 1'b1, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b rdy=%b acc=%h st=%0d expected 0 1 00 0",
               out_valid, in_ready, dbg_acc, dbg_state);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    set_frame(4'b0001, 1'b0);
    send_frame(0, NTAPS - 2, 0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_early: got %b expected 0", out_valid);
    end
    send_frame(NTAPS - 1, NTAPS - 1, 0);
    check_frame("reset_mid_frame", {1'b0, 1'b0, 4'b0101});
    release_output();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W+1:0] exp_v;
    int hold;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NTAPS; i++) begin
        f_p[i]   = DATA_W'($urandom);
        f_sub[i] = 1'($urandom);
        f_ov[i]  = ($urandom_range(0, 7) == 0);
      end
      exp_q.push_back(model_frame());
      send_frame(0, NTAPS - 1, 2);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      exp_v = exp_q.pop_front();
      check_frame($sformatf("rand%0d", f), exp_v);
      release_output();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_mixed_sub();
    test_overflow_flag();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
